// File: rtl/alu_seq_pkg.sv
// Shared definitions for the byte-serial add/subtract sequencer.
// Optional build macro used by the sequencer: ZERO_FLAG_EN (adds the zero result flag).
package alu_seq_pkg;

   localparam int BYTE_W = 8;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_e;

   // Byte index width for a given slice count; at least one bit even for NBYTES=2.
   function automatic int idx_width(input int nbytes);
      return (nbytes <= 2) ? 1 : $clog2(nbytes);
   endfunction

endpackage

// File: rtl/multi_byte_addsub_seq_if.sv
// Start/busy/done handshake and operand/result bus of the byte-serial add/subtract sequencer.
// With ZERO_FLAG_EN defined the bus also carries the zero result flag.
interface multi_byte_addsub_seq_if
   import alu_seq_pkg::*;
#(
   parameter int NBYTES = 4
);
   localparam int W = BYTE_W * NBYTES;

   logic         start;
   logic         sub;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         busy;
   logic         done;
   logic [W-1:0] sum;
   logic         cout;
   logic         of;
`ifdef ZERO_FLAG_EN
   logic         zero;
`endif

   // Issuing control logic side.
   modport master (
      output start, sub, a, b,
`ifdef ZERO_FLAG_EN
      input  zero,
`endif
      input  busy, done, sum, cout, of
   );

   // Sequencer side.
   modport slave (
      input  start, sub, a, b,
`ifdef ZERO_FLAG_EN
      output zero,
`endif
      output busy, done, sum, cout, of
   );

endinterface

// File: rtl/byte_addsub_slice.sv
// One 8-bit ripple-carry add/subtract slice.
// sub only inverts b; the +1 of two's complement arrives through cin on the lowest byte,
// so upper bytes can invert without adding one again.
module byte_addsub_slice
   import alu_seq_pkg::*;
(
   input  logic [BYTE_W-1:0] a,
   input  logic [BYTE_W-1:0] b,
   input  logic              sub,
   input  logic              cin,
   output logic [BYTE_W-1:0] sum,
   output logic              cout,
   output logic              c7
);

   logic [BYTE_W:0]   c;
   logic [BYTE_W-1:0] b_eff;

   // Ripple of eight full adders; c[i] is the carry into bit i.
   always_comb begin
      // NOTE: every variable written here gets a value before any conditional path so no latch is inferred.
      b_eff = b ^ {BYTE_W{sub}};
      sum   = '0;
      c     = '0;
      c[0]  = cin;
      for (int i = 0; i < BYTE_W; i++) begin
         sum[i]   = a[i] ^ b_eff[i] ^ c[i];
         c[i + 1] = (a[i] & b_eff[i]) | (c[i] & (a[i] ^ b_eff[i]));
      end
      cout = c[BYTE_W];
      c7   = c[BYTE_W - 1];
   end

endmodule

// File: rtl/multi_byte_addsub_seq.sv
// Byte-serial wide add/subtract: NBYTES x 8 bits through one 8-bit slice, LSB byte first.
// The carry/borrow is held in a register between bytes; done pulses NBYTES cycles after start.
// Optional build macro: ZERO_FLAG_EN adds a zero result flag registered with cout/of.
module multi_byte_addsub_seq
   import alu_seq_pkg::*;
#(
   parameter int NBYTES = 4
)
(
   input  logic                    clk,
   input  logic                    rst_n,
   multi_byte_addsub_seq_if.slave  bus
);

   localparam int                W        = BYTE_W * NBYTES;
   localparam int                IDX_W    = idx_width(NBYTES);
   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NBYTES - 1);

   state_e            state_q, state_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic              carry_q, carry_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic [W-1:0]      sum_q, sum_d;
   logic              cout_q, cout_d;
   logic              of_q, of_d;
   logic [W-1:0]      a_q, a_d;
   logic [W-1:0]      b_q, b_d;
   logic              sub_q, sub_d;
`ifdef ZERO_FLAG_EN
   logic              zacc_q, zacc_d;
   logic              zero_q, zero_d;
   logic              byte_zero;
`endif

   logic [BYTE_W-1:0] slice_a, slice_b, slice_sum;
   logic              slice_cout, slice_c7;

   assign slice_a = a_q[int'(idx_q) * BYTE_W +: BYTE_W];
   assign slice_b = b_q[int'(idx_q) * BYTE_W +: BYTE_W];

   byte_addsub_slice u_slice (
      .a    (slice_a),
      .b    (slice_b),
      .sub  (sub_q),
      .cin  (carry_q),
      .sum  (slice_sum),
      .cout (slice_cout),
      .c7   (slice_c7)
   );

`ifdef ZERO_FLAG_EN
   assign byte_zero = (slice_sum == '0);
`endif

   // Next-state and result-update logic for the IDLE/RUN sequencer.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      carry_d = carry_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      sum_d   = sum_q;
      cout_d  = cout_q;
      of_d    = of_q;
      a_d     = a_q;
      b_d     = b_q;
      sub_d   = sub_q;
`ifdef ZERO_FLAG_EN
      zacc_d  = zacc_q;
      zero_d  = zero_q;
`endif
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               a_d     = bus.a;
               b_d     = bus.b;
               sub_d   = bus.sub;
               carry_d = bus.sub;   // the +1 of two's complement enters as the first carry-in
               idx_d   = '0;
               busy_d  = 1'b1;
               state_d = RUN;
`ifdef ZERO_FLAG_EN
               zacc_d  = 1'b1;
`endif
            end
         end
         RUN: begin
            sum_d[int'(idx_q) * BYTE_W +: BYTE_W] = slice_sum;
            carry_d = slice_cout;
            idx_d   = idx_q + 1'b1;
`ifdef ZERO_FLAG_EN
            zacc_d  = zacc_q & byte_zero;
`endif
            if (idx_q == LAST_IDX) begin
               cout_d  = slice_cout;
               of_d    = slice_c7 ^ slice_cout;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               idx_d   = '0;
               state_d = IDLE;
`ifdef ZERO_FLAG_EN
               zero_d  = zacc_q & byte_zero;
`endif
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Control and result registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         carry_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         of_q    <= 1'b0;
`ifdef ZERO_FLAG_EN
         zacc_q  <= 1'b0;
         zero_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         carry_q <= carry_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         of_q    <= of_d;
`ifdef ZERO_FLAG_EN
         zacc_q  <= zacc_d;
         zero_q  <= zero_d;
`endif
      end
   end

   // Operand capture registers.
   always_ff @(posedge clk) begin
      // NOTE: operands are not reset; they are only read in RUN, which is always entered through a capture.
      a_q   <= a_d;
      b_q   <= b_d;
      sub_q <= sub_d;
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.sum  = sum_q;
   assign bus.cout = cout_q;
   assign bus.of   = of_q;
`ifdef ZERO_FLAG_EN
   assign bus.zero = zero_q;
`endif

endmodule
